// File: rtl/register_file_mp_pkg.sv
// Shared widths, the hardwired-zero register index and read-source selection
// for the multi-port register file.
package register_file_mp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    SRC_MEM = 2'd0,
    SRC_W0  = 2'd1,
    SRC_W1  = 2'd2
  } rd_src_e;

  // W1 is the load writeback and wins over W0 when both target the read address.
  function automatic rd_src_e pick_src(input bit bypass, input logic w0_hit, input logic w1_hit);
    rd_src_e src;
    src = SRC_MEM;
    if (bypass) begin
      if (w1_hit) begin
        src = SRC_W1;
      end else if (w0_hit) begin
        src = SRC_W0;
      end
    end
    return src;
  endfunction

endpackage

// File: rtl/register_file_mp_read_port.sv
// One registered read port: optional forwarding of same-cycle write data,
// plus the registered pending flag of the addressed register.
module register_file_mp_read_port
  import register_file_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              w0_live,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  input  logic              w1_live,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  input  logic              pend_next,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  rd_src_e           src_sel;
  logic [DATA_W-1:0] data_next;
  logic [DATA_W-1:0] data_reg;
  logic              busy_reg;

  always_comb begin
    src_sel   = pick_src(BYPASS != 0,
                         w0_live && (w0_addr == rd_addr),
                         w1_live && (w1_addr == rd_addr));
    data_next = mem_data;
    case (src_sel)
      SRC_W1:  data_next = w1_data;
      SRC_W0:  data_next = w0_data;
      default: data_next = mem_data;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_reg <= '0;
      busy_reg <= 1'b0;
    end else begin
      data_reg <= data_next;
      busy_reg <= pend_next;
    end
  end

  assign rd_data = data_reg;
  assign rd_busy = busy_reg;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: storage with W1-over-W0 write priority, per-register
// pending scoreboard, and NUM_RD registered read ports.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int BYPASS = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_RD*ADDR_W-1:0] R_Addr,
  output logic [NUM_RD*DATA_W-1:0] R_Data,
  output logic [NUM_RD-1:0]        R_Busy,
  input  logic                     W0_En,
  input  logic [ADDR_W-1:0]        W0_Addr,
  input  logic [DATA_W-1:0]        W0_Data,
  input  logic                     W1_En,
  input  logic [ADDR_W-1:0]        W1_Addr,
  input  logic [DATA_W-1:0]        W1_Data,
  input  logic                     Claim_En,
  input  logic [ADDR_W-1:0]        Claim_Addr,
  output logic                     Any_Busy
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  pending_reg;
  logic [DEPTH-1:0]  pending_next;
  logic              any_busy_reg;
  logic              w0_live;
  logic              w1_live;
  logic              claim_live;

  assign w0_live    = W0_En    && (W0_Addr    != ZERO_ADDR);
  assign w1_live    = W1_En    && (W1_Addr    != ZERO_ADDR);
  assign claim_live = Claim_En && (Claim_Addr != ZERO_ADDR);

  // Register 0 is only ever cleared, so it reads as zero without a special case.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (w1_live && (W1_Addr == ADDR_W'(i))) begin
          mem_reg[i] <= W1_Data;
        end else if (w0_live && (W0_Addr == ADDR_W'(i))) begin
          mem_reg[i] <= W0_Data;
        end
      end
    end
  end

  // A claim is applied after the write clears: it names the newer producer.
  always_comb begin
    pending_next = pending_reg;
    if (w0_live) begin
      pending_next[W0_Addr] = 1'b0;
    end
    if (w1_live) begin
      pending_next[W1_Addr] = 1'b0;
    end
    if (claim_live) begin
      pending_next[Claim_Addr] = 1'b1;
    end
    pending_next[ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_reg  <= '0;
      any_busy_reg <= 1'b0;
    end else begin
      pending_reg  <= pending_next;
      any_busy_reg <= |pending_next;
    end
  end

  assign Any_Busy = any_busy_reg;

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] rd_addr;
      assign rd_addr = R_Addr[gi*ADDR_W +: ADDR_W];

      register_file_mp_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
      ) u_port (
        .CLK       (CLK),
        .RST       (RST),
        .rd_addr   (rd_addr),
        .mem_data  (mem_reg[rd_addr]),
        .w0_live   (w0_live),
        .w0_addr   (W0_Addr),
        .w0_data   (W0_Data),
        .w1_live   (w1_live),
        .w1_addr   (W1_Addr),
        .w1_data   (W1_Data),
        .pend_next (pending_next[rd_addr]),
        .rd_data   (R_Data[gi*DATA_W +: DATA_W]),
        .rd_busy   (R_Busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// Two builds driven in lockstep (4-port with forwarding, 2-port without),
// checked each cycle against an array-level model of the register file.
module tb_register_file_mp;

  logic         CLK = 1'b0;
  logic         RST;
  logic [19:0]  r_addr;
  logic         W0_En, W1_En, Claim_En;
  logic [4:0]   W0_Addr, W1_Addr, Claim_Addr;
  logic [31:0]  W0_Data, W1_Data;
  logic [127:0] a_rdata;
  logic [3:0]   a_busy;
  logic         a_any;
  logic [63:0]  b_rdata;
  logic [1:0]   b_busy;
  logic         b_any;

  logic [31:0]  m_mem [32];
  bit           m_pend [32];
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 CLK = ~CLK;

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(1)) dut_a (
    .CLK(CLK), .RST(RST), .R_Addr(r_addr), .R_Data(a_rdata), .R_Busy(a_busy),
    .W0_En(W0_En), .W0_Addr(W0_Addr), .W0_Data(W0_Data),
    .W1_En(W1_En), .W1_Addr(W1_Addr), .W1_Data(W1_Data),
    .Claim_En(Claim_En), .Claim_Addr(Claim_Addr), .Any_Busy(a_any)
  );

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) dut_b (
    .CLK(CLK), .RST(RST), .R_Addr(r_addr[9:0]), .R_Data(b_rdata), .R_Busy(b_busy),
    .W0_En(W0_En), .W0_Addr(W0_Addr), .W0_Data(W0_Data),
    .W1_En(W1_En), .W1_Addr(W1_Addr), .W1_Data(W1_Data),
    .Claim_En(Claim_En), .Claim_Addr(Claim_Addr), .Any_Busy(b_any)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    W0_En = 1'b0; W0_Addr = '0; W0_Data = '0;
    W1_En = 1'b0; W1_Addr = '0; W1_Data = '0;
    Claim_En = 1'b0; Claim_Addr = '0;
  endtask

  task automatic reads(input logic [4:0] a0, a1, a2, a3);
    r_addr = {a3, a2, a1, a0};
  endtask

  // Advance one edge, update the model from the inputs seen at that edge, compare.
  task automatic tick(input string tag);
    logic [31:0] nm [32];
    bit          np [32];
    logic [31:0] ea [4];
    logic [31:0] eb [2];
    bit          ba [4];
    bit          bb [2];
    bit          any;
    logic [4:0]  a;
    @(posedge CLK);
    any = 1'b0;
    if (RST) begin
      for (int i = 0; i < 32; i++) begin nm[i] = '0; np[i] = 1'b0; end
      for (int k = 0; k < 4; k++) begin ea[k] = '0; ba[k] = 1'b0; end
      for (int k = 0; k < 2; k++) begin eb[k] = '0; bb[k] = 1'b0; end
    end else begin
      nm = m_mem;
      np = m_pend;
      if (W0_En && W0_Addr != 0) begin nm[W0_Addr] = W0_Data; np[W0_Addr] = 1'b0; end
      if (W1_En && W1_Addr != 0) begin nm[W1_Addr] = W1_Data; np[W1_Addr] = 1'b0; end
      if (Claim_En && Claim_Addr != 0) np[Claim_Addr] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        a = r_addr[k*5 +: 5];
        ea[k] = nm[a];
        ba[k] = np[a];
      end
      for (int k = 0; k < 2; k++) begin
        a = r_addr[k*5 +: 5];
        eb[k] = m_mem[a];
        bb[k] = np[a];
      end
      for (int i = 0; i < 32; i++) any |= np[i];
    end
    m_mem  = nm;
    m_pend = np;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s A.data%0d", tag, k), a_rdata[k*32 +: 32], ea[k]);
      chk($sformatf("%s A.busy%0d", tag, k), {31'd0, a_busy[k]}, {31'd0, ba[k]});
    end
    chk($sformatf("%s A.any", tag), {31'd0, a_any}, {31'd0, any});
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s B.data%0d", tag, k), b_rdata[k*32 +: 32], eb[k]);
      chk($sformatf("%s B.busy%0d", tag, k), {31'd0, b_busy[k]}, {31'd0, bb[k]});
    end
    chk($sformatf("%s B.any", tag), {31'd0, b_any}, {31'd0, any});
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_pend[i] = 1'b0; end
    idle();
    reads(0, 0, 0, 0);
    RST = 1'b1;
    tick("reset0");
    tick("reset1");
    RST = 1'b0;

    // Reset wipes a written register.
    W0_En = 1; W0_Addr = 5; W0_Data = 32'h1234; reads(5, 5, 5, 5);
    tick("wr_r5");
    idle(); RST = 1'b1;
    tick("reset_mid");
    RST = 1'b0;
    tick("rd_r5");
    chk("reset r5 data", a_rdata[31:0], 32'h0);
    chk("reset any", {31'd0, a_any}, 32'h0);

    // Dual write to the same register: W1 is kept.
    W0_En = 1; W0_Addr = 3; W0_Data = 32'hAAAA;
    W1_En = 1; W1_Addr = 3; W1_Data = 32'h5555; reads(1, 2, 4, 6);
    tick("dual_wr");
    idle(); reads(3, 3, 3, 3);
    tick("dual_rd");
    chk("dual A r3", a_rdata[31:0], 32'h0000_5555);
    chk("dual B r3", b_rdata[31:0], 32'h0000_5555);

    // Register 0 ignores writes and claims.
    W1_En = 1; W1_Addr = 0; W1_Data = 32'hFFFF_FFFF;
    Claim_En = 1; Claim_Addr = 0; reads(0, 0, 0, 0);
    tick("zero_wr");
    idle();
    tick("zero_rd");
    chk("zero data", a_rdata[31:0], 32'h0);
    chk("zero busy", {28'd0, a_busy}, 32'h0);
    chk("zero any", {31'd0, a_any}, 32'h0);

    // Forwarding versus pre-write contents.
    W0_En = 1; W0_Addr = 7; W0_Data = 32'h11; reads(0, 0, 0, 0);
    tick("byp_setup");
    W0_Data = 32'hCAFE; reads(7, 7, 7, 7);
    tick("byp_same");
    chk("bypass A", a_rdata[31:0], 32'hCAFE);
    chk("nobypass B", b_rdata[31:0], 32'h11);
    idle();
    tick("byp_next");
    chk("nobypass B next", b_rdata[31:0], 32'hCAFE);

    // Scoreboard.
    Claim_En = 1; Claim_Addr = 9; reads(9, 9, 9, 9);
    tick("sb_claim");
    chk("claim busy", {31'd0, a_busy[0]}, 32'h1);
    W0_En = 1; W0_Addr = 9; W0_Data = 32'h99;
    tick("sb_wr_claim");
    chk("wr+claim busy", {31'd0, a_busy[0]}, 32'h1);
    idle(); W1_En = 1; W1_Addr = 9; W1_Data = 32'h77;
    tick("sb_clear");
    chk("clear busy", {31'd0, a_busy[0]}, 32'h0);
    chk("clear any", {31'd0, a_any}, 32'h0);

    // All ports, including repeated and zero addresses.
    idle(); W0_En = 1; W0_Addr = 2; W0_Data = 32'h7;
    W1_En = 1; W1_Addr = 31; W1_Data = 32'h9; reads(0, 0, 0, 0);
    tick("mp_wr");
    idle(); reads(2, 2, 0, 31);
    tick("mp_rd");
    chk("mp p0", a_rdata[31:0],   32'h7);
    chk("mp p1", a_rdata[63:32],  32'h7);
    chk("mp p2", a_rdata[95:64],  32'h0);
    chk("mp p3", a_rdata[127:96], 32'h9);

    // Random traffic with frequent address collisions.
    for (int n = 0; n < 400; n++) begin
      RST        = ($urandom_range(0, 63) == 0);
      W0_En      = 1'($urandom_range(0, 1));
      W0_Addr    = rand_addr();
      W0_Data    = $urandom;
      W1_En      = 1'($urandom_range(0, 1));
      W1_Addr    = rand_addr();
      W1_Data    = $urandom;
      Claim_En   = 1'($urandom_range(0, 1));
      Claim_Addr = rand_addr();
      reads(rand_addr(), rand_addr(), rand_addr(), rand_addr());
      tick($sformatf("rand%0d", n));
    end
    RST = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
